// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the single-bus MiniSRC CPU.
// Fetch runs T0-T2, then a per-opcode execute sequence in T3-T7 returns to T0.
module control_sequencer #(
  parameter int             OPW       = 5,
  parameter logic [4:0]     ADD_CODE  = 5'd3,
  parameter logic [OPW-1:0] HALT_CODE = OPW'(27)
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        conOut,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        read,
  output logic        write,
  output logic        RAMenable,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        R15inC,
  output logic        CSignout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        PortInout,
  output logic        OutPortenable,
  output logic        conin,
  output logic        ZMuxEnable,
  output logic        ZSelect,
  output logic        ZMuxOut,
  output logic [4:0]  aluControl,
  output logic        run
);

  localparam logic [OPW-1:0] OP_LD   = OPW'(0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(11);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
  localparam logic [OPW-1:0] OP_BR   = OPW'(19);
  localparam logic [OPW-1:0] OP_JR   = OPW'(20);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
  localparam logic [OPW-1:0] OP_IN   = OPW'(22);
  localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
  localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
  localparam logic [OPW-1:0] OP_MFLO = OPW'(25);

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [OPW-1:0] op;
  logic [2:0]     last;
  logic           unused_ir;

  assign op        = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  // Final execute step (3..7) of each opcode; everything else ends at T3.
  function automatic logic [2:0] last_step(input logic [OPW-1:0] opc);
    logic [2:0] s;
    case (opc) inside
      OP_LD, OP_ST:                             s = 3'd7;
      OP_MUL, OP_DIV, OP_BR:                    s = 3'd6;
      OP_LDI, [OP_ADD:OP_ROL], [OP_ADDI:OP_ORI]: s = 3'd5;
      OP_NEG, OP_NOT, OP_JAL:                   s = 3'd4;
      default:                                  s = 3'd3;
    endcase
    return s;
  endfunction

  assign last = last_step(op);

  always_ff @(posedge clock) begin
    state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3: begin
        if (op == HALT_CODE)    state_d = S_HALT;
        else if (last == 3'd3)  state_d = S_T0;
        else                    state_d = S_T4;
      end
      S_T4:    state_d = (last == 3'd4) ? S_T0 : S_T5;
      S_T5:    state_d = (last == 3'd5) ? S_T0 : S_T6;
      S_T6:    state_d = (last == 3'd6) ? S_T0 : S_T7;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (!clear) state_d = S_RESET;
  end

  always_comb begin
    PCout = 1'b0; IncPC = 1'b0; PCin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Yin = 1'b0;
    read = 1'b0; write = 1'b0; RAMenable = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
    BAout = 1'b0; R15inC = 1'b0; CSignout = 1'b0;
    HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
    PortInout = 1'b0; OutPortenable = 1'b0; conin = 1'b0;
    ZMuxEnable = 1'b0; ZSelect = 1'b0; ZMuxOut = 1'b0;
    aluControl = 5'd0;
    run = (state_q != S_RESET) && (state_q != S_HALT);
    case (state_q)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
      S_T1: begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (op) inside
          OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; Rout = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          [OP_ADD:OP_ROL], [OP_ADDI:OP_ORI]: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_NEG, OP_NOT: begin
            Grb = 1'b1; Rout = 1'b1; aluControl = 5'(op); ZMuxEnable = 1'b1;
          end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; conin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:  begin PCout = 1'b1; R15inC = 1'b1; end
          OP_IN:   begin PortInout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortenable = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (op) inside
          OP_LD, OP_LDI, OP_ST: begin CSignout = 1'b1; aluControl = ADD_CODE; ZMuxEnable = 1'b1; end
          [OP_ADD:OP_ROL]: begin
            Grc = 1'b1; Rout = 1'b1; aluControl = 5'(op); ZMuxEnable = 1'b1;
          end
          [OP_ADDI:OP_ORI]: begin CSignout = 1'b1; aluControl = 5'(op); ZMuxEnable = 1'b1; end
          OP_MUL, OP_DIV: begin
            Grb = 1'b1; Rout = 1'b1; aluControl = 5'(op); ZMuxEnable = 1'b1;
          end
          OP_NEG, OP_NOT: begin ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (op) inside
          OP_LD, OP_ST: begin ZMuxOut = 1'b1; MARin = 1'b1; end
          OP_LDI, [OP_ADD:OP_ROL], [OP_ADDI:OP_ORI]: begin ZMuxOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MUL, OP_DIV: begin ZMuxOut = 1'b1; LOin = 1'b1; end
          OP_BR: begin CSignout = 1'b1; aluControl = ADD_CODE; ZMuxEnable = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (op) inside
          OP_LD:          begin read = 1'b1; RAMenable = 1'b1; MDRin = 1'b1; end
          OP_ST:          begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          OP_MUL, OP_DIV: begin ZMuxOut = 1'b1; ZSelect = 1'b1; HIin = 1'b1; end
          OP_BR: begin
            ZMuxOut = conOut;
            PCin    = conOut;
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (op) inside
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   begin write = 1'b1; RAMenable = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the single-bus MiniSRC CPU.
- Consumes the instruction register contents and the branch-condition flag from the datapath.
- Produces every datapath control strobe: register-file select/encode, bus drivers, register loads, RAM and port strobes, and ALU/Z-mux controls.
- Runs fetch (T0–T2) then a per-opcode execute sequence (T3–T7), then returns to T0.

Parameters:
- OPW, 5, opcode width; opcode is IR[31:27].
- ADD_CODE, 5'd3, aluControl value used for address and branch-target addition.
- HALT_CODE, 5'd27, opcode that enters HALT.

Ports:
- clock, input, 1, system clock; all state changes on rising edge.
- clear, input, 1, synchronous active-low reset.
- IR, input, 32, instruction register output.
- conOut, input, 1, branch-condition flip-flop output.
- PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, output, 1 each, datapath load/drive strobes.
- read, write, RAMenable, output, 1 each, memory strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, R15inC, output, 1 each, select-and-encode controls.
- CSignout, HIin, LOin, HIout, LOout, PortInout, OutPortenable, conin, output, 1 each, misc strobes.
- ZMuxEnable, ZSelect, ZMuxOut, output, 1 each, Z-mux controls.
  - ZMuxEnable captures the 64-bit ALU result.
  - ZSelect chooses the half: 0 = low, 1 = high.
  - ZMuxOut drives the selected half onto the bus.
- aluControl, output, 5, ALU operation code.
- run, output, 1, high unless in RESET or HALT.

Behaviour:
- State set: RESET, T0..T7, HALT. Outputs are a combinational decode of state and IR[31:27]. Any strobe not listed for a step is 0. aluControl is 0 except where listed.
- clear=0 at a clock edge: next state RESET from any state, including mid-instruction.
  - In RESET all outputs are 0 and run=0.
  - No write or Rin is issued in the cycle after the reset edge.
  - RESET → T0 on the first edge with clear=1.
- Fetch, all opcodes:
  - T0: PCout, MARin, IncPC.
  - T1: read, RAMenable, MDRin.
  - T2: MDRout, IRin.
- Execute steps T3 onward, listed per opcode. The last listed step returns to T0.
- ALU R-type (add 3, sub 4, and 5, or 6, shr 7, shra 8, shl 9, ror 10, rol 11):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, aluControl=op, ZMuxEnable.
  - T5: ZMuxOut, ZSelect=0, Gra, Rin.
- Immediate (addi 12, andi 13, ori 14):
  - T3: Grb, Rout, Yin.
  - T4: CSignout, aluControl=op, ZMuxEnable.
  - T5: ZMuxOut, Gra, Rin.
- ldi 1:
  - T3: Grb, Rout, BAout, Yin.
  - T4: CSignout, aluControl=ADD_CODE, ZMuxEnable.
  - T5: ZMuxOut, Gra, Rin.
- ld 0:
  - T3–T4 as ldi.
  - T5: ZMuxOut, MARin.
  - T6: read, RAMenable, MDRin.
  - T7: MDRout, Gra, Rin.
- st 2:
  - T3–T5 as ld.
  - T6: Gra, Rout, MDRin (read=0).
  - T7: write, RAMenable.
- mul 15, div 16:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, aluControl=op, ZMuxEnable.
  - T5: ZMuxOut, ZSelect=0, LOin.
  - T6: ZMuxOut, ZSelect=1, HIin.
- neg 17, not 18:
  - T3: Grb, Rout, aluControl=op, ZMuxEnable.
  - T4: ZMuxOut, Gra, Rin.
- branch 19:
  - T3: Gra, Rout, conin.
  - T4: PCout, Yin.
  - T5: CSignout, aluControl=ADD_CODE, ZMuxEnable.
  - T6: if conOut=1, ZMuxOut and PCin; if conOut=0, no strobes.
- jr 20:
  - T3: Gra, Rout, PCin.
- jal 21:
  - T3: PCout, R15inC.
  - T4: Gra, Rout, PCin.
- in 22:
  - T3: PortInout, Gra, Rin.
- out 23:
  - T3: Gra, Rout, OutPortenable.
- mfhi 24 and mflo 25:
  - T3: HIout (mfhi) or LOout (mflo), Gra, Rin.
- nop 26 and undefined opcodes 28–31:
  - T3 has no strobes; then T0.
- HALT_CODE:
  - T3 → HALT. HALT holds, all outputs 0, run=0, until clear=0.
- Invariants:
  - At most one bus driver is active per cycle.
  - read and write are never both high.
  - The opcode is read from IR only in T3..T7. IR is stable there because IRin is asserted only in T2.
- Latency, including 3 fetch cycles: ALU R-type 6, ld 8, st 8, branch 7, jr 4, nop 4.

Test Plan:
- Reset, then IR=add R5,R2,R4 (opcode 3, ra=5, rb=2, rc=4) → T3 Grb+Rout+Yin; T4 Grc+Rout+aluControl=3+ZMuxEnable; T5 ZMuxOut+Gra+Rin; back at T0 on cycle 7.
- ld R1,0x55(R0) → BAout in T3; MARin in T5; read+RAMenable+MDRin in T6; MDRout+Gra+Rin in T7; 8 cycles total; write=0 throughout.
- st opcode 2 → write=1 and RAMenable=1 only in T7; read=0 in T6–T7.
- Branch with conOut=1 → PCin in T6; repeat with conOut=0 → PCin stays 0 in T6 and T0 follows.
- mul opcode 15 → LOin with ZSelect=0 in T5, HIin with ZSelect=1 in T6; never both in the same cycle.
- clear=0 asserted in T6 of st → RESET next cycle, write never asserted; HALT opcode 27 → run=0 and outputs frozen at 0 for 20 cycles until clear=0.
